flit_rx_unpack: RTL
===================

FLIT_RX_UNPACK -- requirements
Module: flit_rx_unpack

Interface
REQ-001 SHALL have parameter LOCAL_ADDR, default 4'b0001, the 4-bit node address this receiver accepts.
REQ-002 SHALL have parameter DEPTH, default 4, entries per operand FIFO (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port input_flit  input  71  flit: [70] valid, [69] type (ignored), [68:65] dest, [64] vc/operand slot (0=A, 1=B), [63:0] data.
REQ-006 SHALL have port flit_valid  input  1  sender strobe; it is driven by the ready_send output of a PE transmitter.
REQ-007 SHALL have port in_ready  output  1  combinational; high when the flit on input_flit can be taken this cycle.
REQ-008 SHALL have port operand_a  output  64  registered operand A of the presented pair.
REQ-009 SHALL have port operand_b  output  64  registered operand B of the presented pair.
REQ-010 SHALL have port pair_valid  output  1  registered; high while operand_a/operand_b hold an unconsumed pair.
REQ-011 SHALL have port pair_ready  input  1  consumer accepts the pair on a cycle with pair_valid high.
REQ-012 SHALL have port drop_cnt  output  8  count of discarded flits.

Function
REQ-013 SHALL define the accept event as: flit_valid and in_ready both high at a rising clk edge.
REQ-014 SHALL drive in_ready = NOT fifo_full[input_flit[64]].
- Discard-class flits (REQ-015) SHALL additionally drive in_ready high regardless of FIFO state.
REQ-015 SHALL discard an accepted flit if input_flit[70]=0 or input_flit[68:65]!=LOCAL_ADDR, and SHALL increment drop_cnt for it.
- drop_cnt SHALL saturate at 255.
REQ-016 SHALL push input_flit[63:0] into FIFO A (vc=0) or FIFO B (vc=1) on every accepted, non-discarded flit.
REQ-017 SHALL keep each FIFO DEPTH deep, strict in-order, with wrap-around read/write pointers and an occupancy count 0..DEPTH.
REQ-018 SHALL define a pair-load condition on a rising edge: both FIFOs non-empty AND (pair_valid=0 OR pair_ready=1).
REQ-019 SHALL, on a pair-load edge, load the FIFO A head into operand_a and the FIFO B head into operand_b, set pair_valid=1, and pop both FIFOs.
REQ-020 SHALL clear pair_valid on an edge where pair_valid=1, pair_ready=1 and the pair-load condition is false.
REQ-021 SHALL hold operand_a, operand_b and pair_valid stable while pair_valid=1 and pair_ready=0.
REQ-022 SHALL give a latency of one edge: when the completing operand is accepted at edge N and the output register is free, pair_valid SHALL be high after edge N+1.
REQ-023 SHALL support a push and a pop on the same FIFO at the same edge.
- Occupancy SHALL be unchanged in that case.
- A push into an empty FIFO SHALL NOT be visible to the pop at that same edge.
REQ-024 SHALL sustain one pair per cycle under continuous pair_ready=1 when both FIFOs are fed.
REQ-025 SHALL never overwrite a FIFO entry when that FIFO is full and never pop an empty FIFO.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-transfer, immediately clear all of the following:
- FIFO pointers and counts;
- pair_valid;
- operand_a and operand_b (to 0);
- drop_cnt (to 0).
REQ-027 SHALL, while rst_n=0, drive in_ready=1 (the FIFOs are empty) but accept nothing.
REQ-028 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-029 Scenario: A flit data=5 (vc=0, dest=0001) then B flit data=8 (vc=1), pair_ready=1 -> pair_valid high one edge after the B accept, operand_a=5, operand_b=8.
REQ-030 Scenario: 5 A-flits with no B flits, DEPTH=4 -> 4 accepted, in_ready=0 for the 5th while its vc=0; a vc=1 flit is still accepted in that state.
REQ-031 Scenario: flits with dest=0110 and with bit70=0 -> none enqueued, drop_cnt=2; then 300 misrouted flits -> drop_cnt=255.
REQ-032 Scenario: 3 A/B pairs (1/2, 3/4, 5/6) with pair_ready=0 for 5 cycles, then 1 -> pairs delivered in order, operands stable during the stall.
REQ-033 Scenario: rst_n pulsed low with 2 entries in FIFO A and pair_valid=1 -> pair_valid=0, drop_cnt=0 and outputs cleared asynchronously; a subsequent B flit alone yields no pair.
REQ-034 Scenario: continuous interleaved A/B traffic with pair_ready=1 -> pair throughput matches the arrival rate with no loss or duplication.

Source files
------------

// File: rtl/flit_rx_unpack.sv
// Flit receiver and operand unpacker.
// Flits addressed to LOCAL_ADDR are steered by their vc bit into FIFO A or
// FIFO B. When both FIFOs hold data, their heads are popped together into a
// registered operand pair with a valid/ready handshake. Flits that are not
// valid or not addressed here are always taken and counted as drops.
module flit_rx_unpack #(
  parameter logic [3:0] LOCAL_ADDR = 4'b0001,
  parameter int         DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [70:0] input_flit,
  input  logic        flit_valid,
  output logic        in_ready,
  output logic [63:0] operand_a,
  output logic [63:0] operand_b,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [7:0]  drop_cnt
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Flit field decode
  logic        flit_bit_valid;
  logic        unused_type;
  logic [3:0]  dest;
  logic        vc;
  logic [63:0] data;

  assign flit_bit_valid = input_flit[70];
  assign unused_type    = input_flit[69];
  assign dest           = input_flit[68:65];
  assign vc             = input_flit[64];
  assign data           = input_flit[63:0];

  // FIFO storage and bookkeeping
  logic [63:0]      mem_a [DEPTH];
  logic [63:0]      mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr_a, rd_ptr_a, wr_ptr_b, rd_ptr_b;
  logic [PTR_W:0]   cnt_a, cnt_b;

  logic full_a, full_b, empty_a, empty_b;
  logic discard, accept, push_a, push_b, pair_load;

  assign full_a  = (cnt_a == FULL_CNT);
  assign full_b  = (cnt_b == FULL_CNT);
  assign empty_a = (cnt_a == '0);
  assign empty_b = (cnt_b == '0);

  // Discarded flits never touch a FIFO, so they are taken even when the
  // FIFO their vc bit names is full.
  assign discard  = ~flit_bit_valid | (dest != LOCAL_ADDR);
  assign in_ready = discard | (vc ? ~full_b : ~full_a);
  assign accept   = flit_valid & in_ready;
  assign push_a   = accept & ~discard & ~vc;
  assign push_b   = accept & ~discard &  vc;

  // Load decision uses occupancy before this edge's push, so a flit written
  // into an empty FIFO is only poppable from the following edge.
  assign pair_load = ~empty_a & ~empty_b & (~pair_valid | pair_ready);

  // FIFO A data write
  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_ptr_a] <= data;
  end

  // FIFO B data write
  always_ff @(posedge clk) begin
    if (push_b) mem_b[wr_ptr_b] <= data;
  end

  // FIFO A pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_a <= '0;
      rd_ptr_a <= '0;
      cnt_a    <= '0;
    end else begin
      if (push_a)    wr_ptr_a <= wr_ptr_a + PTR_ONE;
      if (pair_load) rd_ptr_a <= rd_ptr_a + PTR_ONE;
      case ({push_a, pair_load})
        2'b10:   cnt_a <= cnt_a + CNT_ONE;
        2'b01:   cnt_a <= cnt_a - CNT_ONE;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  // FIFO B pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_b <= '0;
      rd_ptr_b <= '0;
      cnt_b    <= '0;
    end else begin
      if (push_b)    wr_ptr_b <= wr_ptr_b + PTR_ONE;
      if (pair_load) rd_ptr_b <= rd_ptr_b + PTR_ONE;
      case ({push_b, pair_load})
        2'b10:   cnt_b <= cnt_b + CNT_ONE;
        2'b01:   cnt_b <= cnt_b - CNT_ONE;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

  // Output pair register: load on pair_load, retire when consumed, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_a  <= '0;
      operand_b  <= '0;
      pair_valid <= 1'b0;
    end else if (pair_load) begin
      operand_a  <= mem_a[rd_ptr_a];
      operand_b  <= mem_b[rd_ptr_b];
      pair_valid <= 1'b1;
    end else if (pair_valid && pair_ready) begin
      pair_valid <= 1'b0;
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (accept && discard && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
